// File: rtl/aes_inv_keysched.sv
// AES-128 inverse-cipher round-key generator and store.
// Runs the forward key expansion one round per cycle while the controller is
// in its pre-expansion phase, keeps all NR+1 round keys, and serves them in
// reverse order on each AddRoundKey (ADD) state of the inverse cipher.
module aes_inv_keysched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         res,
    input  logic [2:0]   cs,
    input  logic [7:0]   cot,
    input  logic [127:0] key_in,
    output logic [127:0] rkey,
    output logic         rkey_vld,
    output logic         kdone,
    output logic         err
);

    localparam logic [2:0] ST_STL = 3'b001;
    localparam logic [2:0] ST_ADD = 3'b010;
    localparam logic [2:0] ST_INV = 3'b110;

    localparam logic [7:0] NR_B   = 8'(NR);
    localparam logic [7:0] LAST_B = 8'(2 * NR);

    // Forward AES S-box, row-major: SBOX[8'hXY] is row X, column Y.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for expansion rounds 1..10; zero elsewhere.
    function automatic logic [7:0] rcon(input logic [7:0] r);
        logic [7:0] v;
        case (r)
            8'd1:    v = 8'h01;
            8'd2:    v = 8'h02;
            8'd3:    v = 8'h04;
            8'd4:    v = 8'h08;
            8'd5:    v = 8'h10;
            8'd6:    v = 8'h20;
            8'd7:    v = 8'h40;
            8'd8:    v = 8'h80;
            8'd9:    v = 8'h1b;
            8'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    logic [127:0] rk [0:NR];
    logic [127:0] wk;

    logic [31:0]  temp;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] nxt;

    logic load, exp_ok, inv_bad, add, add_rng, add_bad;

    // Next round key from the working register and the current round number.
    always_comb begin
        temp = subword({wk[23:0], wk[31:24]}) ^ {rcon(cot), 24'h0};
        n0   = wk[127:96] ^ temp;
        n1   = wk[95:64]  ^ n0;
        n2   = wk[63:32]  ^ n1;
        n3   = wk[31:0]   ^ n2;
        nxt  = {n0, n1, n2, n3};
    end

    // Decode of the controller state/counter into the actions of this cycle.
    always_comb begin
        load    = (cs == ST_STL) && (cot == 8'd0);
        exp_ok  = (cs == ST_INV) && (cot >= 8'd1) && (cot <= NR_B);
        inv_bad = (cs == ST_INV) && !exp_ok;
        add     = (cs == ST_ADD);
        add_rng = (cot >= NR_B) && (cot <= LAST_B);
        add_bad = add && (!kdone || !add_rng);
    end

    // Key storage, expansion progress and sticky error flag.
    always_ff @(posedge clk) begin
        if (res) begin
            wk    <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
            kdone <= 1'b0;
            err   <= 1'b0;
        end else if (load) begin
            wk    <= key_in;
            rk[0] <= key_in;
            kdone <= 1'b0;
            err   <= 1'b0;
        end else if (exp_ok) begin
            wk <= nxt;
            for (int i = 1; i <= NR; i++) begin
                if (cot == 8'(i)) rk[i] <= nxt;
            end
            if (cot == NR_B) kdone <= 1'b1;
        end else if (inv_bad || add_bad) begin
            err <= 1'b1;
        end
    end

    // Reverse-order readout: ADD at cot=NR uses rk[NR], cot=2*NR uses rk[0].
    always_comb begin
        rkey     = '0;
        rkey_vld = 1'b0;
        if (add && add_rng) begin
            for (int i = 0; i <= NR; i++) begin
                if ((LAST_B - cot) == 8'(i)) rkey = rk[i];
            end
            rkey_vld = kdone;
        end
    end

endmodule

// File: doc/aes_inv_keysched.md
Name: aes_inv_keysched

Overview:
- Round-key generator and store for the AES-128 inverse cipher.
- Sits directly downstream of the inverse-cipher state controller and consumes its state code `cs` and round counter `cot`.
- During the controller's pre-expansion phase (STL/INV) it runs the forward FIPS-197 key expansion one round per cycle and stores all 11 round keys.
- During decryption it serves them in reverse order to the AddRoundKey datapath on every ADD state.

Parameters:
- NR, 10, number of AES rounds (only 10 / AES-128 supported; other values are out of scope).

Ports:
- clk  input  1  system clock, rising-edge.
- res  input  1  reset; synchronous, active-high.
- cs  input  3  controller state: RES=000, STL=001, ADD=010, SUB=011, SHI=100, MIX=101, INV=110, FIN=111.
- cot  input  8  controller round counter.
- key_in  input  128  cipher key; bits [127:96] = w0; sampled only when cs==STL and cot==0.
- rkey  output  128  round key for the current ADD state.
- rkey_vld  output  1  rkey is valid for use this cycle.
- kdone  output  1  all 11 round keys stored.
- err  output  1  sticky protocol error.

Behaviour:
- Storage:
  - rk[0..10], 128-bit registers, plus working register wk (128 bit).
  - All are cleared to 0 by reset.
- Reset (res==1 at a clk edge):
  - rk, wk, kdone and err are cleared to 0.
  - Reset has priority over all other activity, including mid-expansion or mid-decryption.
- Load (cs==STL and cot==0):
  - wk<=key_in and rk[0]<=key_in.
  - kdone<=0 and err<=0; this also restarts a schedule that was in progress.
- Expansion (cs==INV and 1<=cot<=10), one round per cycle:
  - temp = SubWord(RotWord(wk[31:0])) ^ {rcon(cot),24'h0}.
  - RotWord is a 1-byte left rotate; SubWord applies the forward S-box to each byte.
  - n0 = wk[127:96]^temp; n1 = wk[95:64]^n0; n2 = wk[63:32]^n1; n3 = wk[31:0]^n2.
  - wk<={n0,n1,n2,n3} and rk[cot]<={n0,n1,n2,n3}.
  - rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
  - When cot==10 the store completes and kdone<=1 takes effect on the same edge.
- Controller timing:
  - After load, the controller presents INV with cot=1..10 on consecutive cycles.
  - The 10 rounds take exactly 10 cycles, and kdone rises at the edge that ends the INV/cot=10 cycle.
- INV with cot==0 or cot>10: no write, and err<=1.
- Readout (combinational, zero latency):
  - When cs==ADD and 10<=cot<=20: rkey = rk[20-cot] and rkey_vld = kdone.
  - Otherwise rkey = 128'h0 and rkey_vld = 0.
  - The controller issues ADD at cot=10 (uses rk[10]) through cot=20 (uses rk[0], final round).
- Error conditions:
  - cs==ADD while kdone==0 sets err<=1. rkey still shows the stored value; rkey_vld is 0.
  - cs==ADD with cot outside 10..20 sets err<=1.
  - err is sticky; it clears only on reset or on a new load.
- All other states (SUB, SHI, MIX, FIN, RES, STL with cot!=0):
  - No register change.
  - The rk contents persist through FIN, so the key can be reused.
- Width rule: 20-cot is computed in 8 bits. The index is used only inside the 10..20 range, so no wrap is possible.
- No storage is written outside the load and expansion cases.

Test Plan:
- Reset behaviour: res=1 for 2 cycles, with any cs/cot -> kdone=0, err=0, rkey_vld=0, rkey=0, and all rk read back 0 afterwards via ADD sweeps. err must then be 1 from the ADD with kdone=0.
- FIPS-197 A.1 expansion: key_in=2b7e151628aed2a6abf7158809cf4f3c, drive STL/cot0 then INV/cot1..10 ->
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - kdone=1 exactly one edge after the INV/cot=10 cycle.
- Reverse readout using the A.1 key:
  - ADD/cot=10 -> rkey=d014f9a8...0ca6, rkey_vld=1.
  - ADD/cot=20 -> rkey=2b7e1516...4f3c.
  - SUB/SHI/MIX cycles -> rkey=0, rkey_vld=0.
- C.1 full sequence: run the real controller sequence with key 000102030405060708090a0b0c0d0e0f -> ADD/cot=10 gives 13111d7fe3944a17f307a78b4d2b30c5, and err stays 0 through FIN.
- Restart and mid-operation reset:
  - Assert res during INV/cot=5 -> all state cleared, kdone=0.
  - Reload with a new key -> the correct new rk[10] is produced.
  - Separately, a second STL/cot0 after FIN clears kdone and err and overwrites rk[0].
- Protocol errors:
  - ADD/cot=12 before kdone -> err=1, rkey_vld=0.
  - ADD/cot=25 after kdone -> err=1, rkey=0.
  - err holds until the next load or reset.
